// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the message-granular UART TX arbiter.
// Imported by the picker and the arbiter top.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Width of a requester index; never below one bit so that two requesters still get a real select.
    function automatic int grant_idx_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/uart_tx_msg_arbiter_if.sv
// Byte-stream bundle between the message sources, the arbiter and the UART TX serializer.
// The master side is the environment (sources plus serializer); the slave side is the arbiter.
interface uart_tx_msg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: returns the first set request found searching
// upward from rr_ptr with wrap-around.
module rr_priority_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = grant_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               any,
    output logic [IW-1:0]      index
);
    localparam int            SW    = IW + 1;
    localparam logic [SW-1:0] N_REQ = SW'(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      off;
    logic [SW-1:0]      idx_sum;

    // rot[gi] is the request that sits gi positions after rr_ptr.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [SW-1:0] sum;
            logic [IW-1:0] pos;
            assign sum     = {1'b0, rr_ptr} + SW'(gi);
            assign pos     = IW'((sum >= N_REQ) ? (sum - N_REQ) : sum);
            assign rot[gi] = req[pos];
        end
    endgenerate

    always_comb begin
        any = 1'b0;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                off = IW'(i);
            end
        end
    end

    assign idx_sum = {1'b0, rr_ptr} + {1'b0, off};
    assign index   = IW'((idx_sum >= N_REQ) ? (idx_sum - N_REQ) : idx_sum);

endmodule

// File: rtl/uart_tx_msg_arbiter.sv
// Shares one UART TX byte channel among NUM_REQ requesters, one whole message at a time,
// with round-robin selection and forced release after MAX_MSG_LEN beats.
module uart_tx_msg_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int MAX_MSG_LEN = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    uart_tx_msg_arbiter_if.slave       bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       trunc_err
);
    localparam int            GW       = grant_idx_w(NUM_REQ);
    localparam int            CW       = $clog2(MAX_MSG_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_MSG_LEN - 1);
    localparam logic [GW-1:0] GID_LAST = GW'(NUM_REQ - 1);

    arb_state_e    state_reg, state_next;
    logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [GW-1:0] grant_id_reg, grant_id_next;
    logic [CW-1:0] beat_cnt_reg, beat_cnt_next;

    logic              pick_any;
    logic [GW-1:0]     pick_idx;
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              beat;
    logic              force_rel;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (GW)
    ) u_pick (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr_reg),
        .any    (pick_any),
        .index  (pick_idx)
    );

    assign sel_valid = bus.req_valid[grant_id_reg];
    assign sel_last  = bus.req_last[grant_id_reg];
    assign sel_data  = data_arr[grant_id_reg];
    assign beat      = (state_reg == XFER) && sel_valid && bus.tx_ready;
    // Forced release only when the limit beat itself is not the message's last byte.
    assign force_rel = beat && !sel_last && (beat_cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_id_reg <= grant_id_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_id_next = grant_id_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    grant_id_next = pick_idx;
                    beat_cnt_next = '0;
                    state_next    = XFER;
                end
            end
            XFER: begin
                if (beat) begin
                    if (sel_last || force_rel) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                        rr_ptr_next   = (grant_id_reg == GID_LAST) ? '0 : grant_id_reg + 1'b1;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        busy          = 1'b0;
        trunc_err     = 1'b0;
        if (state_reg == XFER) begin
            busy                        = 1'b1;
            bus.tx_valid                = sel_valid;
            bus.tx_data                 = sel_valid ? sel_data : '0;
            bus.req_ready[grant_id_reg] = bus.tx_ready;
            trunc_err                   = force_rel;
        end
    end

    assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_msg_arbiter.sv
// Directed bench for uart_tx_msg_arbiter: a per-cycle vector table for reset, a single
// message and a four-way round, then source-driven sequences for truncation, stalls and reset.
module tb_uart_tx_msg_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    grant_id;
    logic          busy;
    logic          trunc_err;

    always #5 clk = ~clk;

    uart_tx_msg_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    uart_tx_msg_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .MAX_MSG_LEN (256)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .trunc_err (trunc_err)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [3:0]  rl;
        logic [31:0] rd;
        logic        tr;
        logic [3:0]  e_rr;
        logic        e_tv;
        logic [7:0]  e_td;
        logic        e_busy;
        logic [1:0]  e_gid;
        logic        e_trunc;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // Source-driven harness state
    int         src_len [NR];
    int         src_ptr [NR];
    logic [7:0] src_base [NR];
    bit         gap_mode;
    bit         toggle_mode;
    int         cyc;
    logic [1:0] log_gid [$];
    logic [7:0] log_data [$];
    int         trunc_cnt;
    int         trunc_idx;
    int         viol;
    logic       prev_stall;
    logic [7:0] prev_td;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] rv, input logic [3:0] rl,
                       input logic [31:0] rd, input logic tr, input logic [3:0] e_rr,
                       input logic e_tv, input logic [7:0] e_td, input logic e_busy,
                       input logic [1:0] e_gid, input logic e_trunc);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rl = rl; v.rd = rd; v.tr = tr;
        v.e_rr = e_rr; v.e_tv = e_tv; v.e_td = e_td; v.e_busy = e_busy;
        v.e_gid = e_gid; v.e_trunc = e_trunc;
        vecs.push_back(v);
    endtask

    function automatic logic [16:0] outs();
        return {bus.req_ready, bus.tx_valid, bus.tx_data, busy, grant_id, trunc_err};
    endfunction

    task automatic drive_src();
        bit gap;
        gap = gap_mode && ((cyc % 5) == 3);
        for (int i = 0; i < NR; i++) begin
            if (src_ptr[i] < src_len[i] && !gap) begin
                bus.req_valid[i]          = 1'b1;
                bus.req_data[i*DW +: DW]  = src_base[i] + 8'(src_ptr[i]);
                bus.req_last[i]           = (src_ptr[i] == src_len[i] - 1);
            end else begin
                bus.req_valid[i]          = 1'b0;
                bus.req_data[i*DW +: DW]  = 8'h00;
                bus.req_last[i]           = 1'b0;
            end
        end
        bus.tx_ready = toggle_mode ? cyc[0] : 1'b1;
    endtask

    // One clock of the source harness: drive, observe before the edge, advance accepted sources.
    task automatic run_cycle();
        logic [3:0] acc;
        @(negedge clk);
        drive_src();
        #1;
        if (!bus.tx_valid && bus.tx_data != 8'h00) viol++;
        if (prev_stall && bus.tx_valid && bus.tx_data != prev_td) viol++;
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_td    = bus.tx_data;
        if (bus.tx_valid && bus.tx_ready) begin
            if (trunc_err) begin
                trunc_cnt++;
                trunc_idx = log_data.size();
            end
            log_gid.push_back(grant_id);
            log_data.push_back(bus.tx_data);
        end
        acc = bus.req_ready & bus.req_valid;
        @(posedge clk);
        for (int i = 0; i < NR; i++) if (acc[i]) src_ptr[i]++;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0; src_ptr[i] = 0; src_base[i] = 8'h00;
        end
        gap_mode = 1'b0; toggle_mode = 1'b0; cyc = 0;
        drive_src();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        log_gid.delete(); log_data.delete();
        trunc_cnt = 0; trunc_idx = -1; viol = 0; prev_stall = 1'b0; prev_td = 8'h00;
    endtask

    function automatic bit srcs_done();
        for (int i = 0; i < NR; i++) if (src_ptr[i] < src_len[i]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        int n;
        int mism;
        int first_bad;
        logic [7:0] ed;
        logic [1:0] eg;

        reset = 1'b1;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.tx_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held with every requester asking
        for (int i = 0; i < 10; i++)
            add(1, 4'hF, 4'h0, 32'h31211101, 1, 4'h0, 0, 8'h00, 0, 2'd0, 0);
        // "HI\n" from requester 0
        add(0, 4'h1, 4'h0, 32'h00000048, 1, 4'h0, 0, 8'h00, 0, 2'd0, 0);
        add(0, 4'h1, 4'h0, 32'h00000048, 1, 4'h1, 1, 8'h48, 1, 2'd0, 0);
        add(0, 4'h1, 4'h0, 32'h00000049, 1, 4'h1, 1, 8'h49, 1, 2'd0, 0);
        add(0, 4'h1, 4'h1, 32'h0000000A, 1, 4'h1, 1, 8'h0A, 1, 2'd0, 0);
        add(0, 4'h0, 4'h0, 32'h00000000, 1, 4'h0, 0, 8'h00, 0, 2'd0, 0);
        add(1, 4'h0, 4'h0, 32'h00000000, 1, 4'h0, 0, 8'h00, 0, 2'd0, 0);
        // Four 2-byte messages at once: served 0,1,2,3 with no interleave
        add(0, 4'hF, 4'h0, 32'h31211101, 1, 4'h0, 0, 8'h00, 0, 2'd0, 0);
        add(0, 4'hF, 4'h0, 32'h31211101, 1, 4'h1, 1, 8'h01, 1, 2'd0, 0);
        add(0, 4'hF, 4'h1, 32'h31211102, 1, 4'h1, 1, 8'h02, 1, 2'd0, 0);
        add(0, 4'hE, 4'h0, 32'h31211100, 1, 4'h0, 0, 8'h00, 0, 2'd0, 0);
        add(0, 4'hE, 4'h0, 32'h31211100, 1, 4'h2, 1, 8'h11, 1, 2'd1, 0);
        add(0, 4'hE, 4'h2, 32'h31211200, 1, 4'h2, 1, 8'h12, 1, 2'd1, 0);
        add(0, 4'hC, 4'h0, 32'h31210000, 1, 4'h0, 0, 8'h00, 0, 2'd1, 0);
        add(0, 4'hC, 4'h0, 32'h31210000, 1, 4'h4, 1, 8'h21, 1, 2'd2, 0);
        add(0, 4'hC, 4'h4, 32'h31220000, 1, 4'h4, 1, 8'h22, 1, 2'd2, 0);
        add(0, 4'h8, 4'h0, 32'h31000000, 1, 4'h0, 0, 8'h00, 0, 2'd2, 0);
        add(0, 4'h8, 4'h0, 32'h31000000, 1, 4'h8, 1, 8'h31, 1, 2'd3, 0);
        add(0, 4'h8, 4'h8, 32'h32000000, 1, 4'h8, 1, 8'h32, 1, 2'd3, 0);
        add(0, 4'h0, 4'h0, 32'h00000000, 1, 4'h0, 0, 8'h00, 0, 2'd3, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset         = vecs[i].rst;
            bus.req_valid = vecs[i].rv;
            bus.req_last  = vecs[i].rl;
            bus.req_data  = vecs[i].rd;
            bus.tx_ready  = vecs[i].tr;
            #1;
            check($sformatf("vec%0d", i), 64'(outs()),
                  64'({vecs[i].e_rr, vecs[i].e_tv, vecs[i].e_td, vecs[i].e_busy,
                       vecs[i].e_gid, vecs[i].e_trunc}));
        end

        // 300-byte message on requester 2 truncated at 256; requester 1 served before it resumes
        do_reset();
        src_len[2] = 300; src_base[2] = 8'h00;
        repeat (3) run_cycle();
        src_len[1] = 3; src_base[1] = 8'hA0;
        n = 0;
        while (!(srcs_done() && !busy) && n < 500) begin
            run_cycle();
            n++;
        end
        check("trunc_done", 64'(n < 500), 64'd1);
        check("trunc_pulses", 64'(trunc_cnt), 64'd1);
        check("trunc_beat", 64'(trunc_idx), 64'd255);
        check("trunc_len", 64'(log_data.size()), 64'd303);
        mism = 0; first_bad = -1;
        for (int k = 0; k < log_data.size() && k < 303; k++) begin
            if (k < 256)      begin eg = 2'd2; ed = 8'(k); end
            else if (k < 259) begin eg = 2'd1; ed = 8'hA0 + 8'(k - 256); end
            else              begin eg = 2'd2; ed = 8'(k - 3); end
            if (log_gid[k] !== eg || log_data[k] !== ed) begin
                mism++;
                if (first_bad < 0) first_bad = k;
            end
        end
        check("trunc_order_bad_beats", 64'(mism), 64'd0);

        // Ready toggling and valid gaps inside a 10-byte message
        do_reset();
        toggle_mode = 1'b1; gap_mode = 1'b1;
        src_len[0] = 10; src_base[0] = 8'h30;
        n = 0;
        while (!(srcs_done() && !busy) && n < 100) begin
            run_cycle();
            n++;
        end
        check("stall_done", 64'(n < 100), 64'd1);
        check("stall_viol", 64'(viol), 64'd0);
        check("stall_len", 64'(log_data.size()), 64'd10);
        mism = 0;
        for (int k = 0; k < log_data.size(); k++)
            if (log_data[k] !== 8'h30 + 8'(k) || log_gid[k] !== 2'd0) mism++;
        check("stall_bytes_bad", 64'(mism), 64'd0);
        check("stall_trunc", 64'(trunc_cnt), 64'd0);

        // Reset in the middle of requester 1's message
        do_reset();
        src_len[1] = 10; src_base[1] = 8'h50;
        n = 0;
        while (log_data.size() < 5 && n < 30) begin
            run_cycle();
            n++;
        end
        check("rst_mid_reach5", 64'(log_data.size()), 64'd5);
        check("rst_mid_busy_before", 64'({busy, grant_id}), 64'({1'b1, 2'd1}));
        @(negedge clk);
        reset = 1'b1;
        src_len[0] = 2; src_base[0] = 8'hC0; src_ptr[0] = 0;
        drive_src();
        @(posedge clk);
        @(negedge clk);
        drive_src();
        #1;
        check("rst_mid_outputs", 64'(outs()), 64'd0);
        reset = 1'b0;
        src_ptr[1] = 0;
        log_gid.delete(); log_data.delete();
        n = 0;
        while (log_data.size() < 1 && n < 10) begin
            run_cycle();
            n++;
        end
        check("rst_first_winner", 64'({log_gid.size() > 0 ? log_gid[0] : 2'd3,
                                        log_data.size() > 0 ? log_data[0] : 8'hFF}),
              64'({2'd0, 8'hC0}));
        n = 0;
        while (!(srcs_done() && !busy) && n < 60) begin
            run_cycle();
            n++;
        end
        check("rst_after_len", 64'(log_data.size()), 64'd12);
        check("rst_after_trunc", 64'(trunc_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
